// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing source: pattern
// selector encoding, colour-bar table and default 640x480@60 timing.
package video_timing_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    // 640x480@60 (25.175 MHz pixel clock) raster.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [23:0] DEF_SOLID_RGB = 24'h808080;

    // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_TABLE [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern generator: maps the current raster position
// and latched pattern selection to a 24-bit RGB value, black in blanking.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int          H_ACTIVE  = DEF_H_ACTIVE,
    parameter logic [23:0] SOLID_RGB = DEF_SOLID_RGB
) (
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  pattern_e    pat,
    input  logic        de,
    output logic [23:0] rgb
);

    // Integer bar width; pixels beyond 8*BAR_W fall into index >= 8 (black).
    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

    logic [11:0] bar_idx_s;
    logic        chk_s;

    assign bar_idx_s = x / BAR_W;
    // 32x32 squares: bit 5 of x xor bit 5 of y.
    assign chk_s     = 1'((x ^ y) >> 3'd5);

    // Select the pattern colour for the active pixel; blank outside active video.
    always_comb begin
        rgb = 24'h000000;
        if (!de) begin
            rgb = 24'h000000;
        end else begin
            case (pat)
                PAT_BARS: begin
                    if (bar_idx_s < 12'd8) begin
                        rgb = bar_colour(bar_idx_s[2:0]);
                    end else begin
                        rgb = 24'h000000;
                    end
                end
                PAT_GRAD:  rgb = {x[7:0], x[7:0], x[7:0]};
                PAT_CHECK: rgb = chk_s ? 24'hFFFFFF : 24'h000000;
                PAT_SOLID: rgb = SOLID_RGB;
                default:   rgb = 24'h000000;
            endcase
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock raster timing generator with registered sync/de/RGB outputs
// feeding the TMDS encoder. All outputs lag the counters by one clock.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int          H_ACTIVE  = DEF_H_ACTIVE,
    parameter int          H_FP      = DEF_H_FP,
    parameter int          H_SYNC    = DEF_H_SYNC,
    parameter int          H_BP      = DEF_H_BP,
    parameter int          V_ACTIVE  = DEF_V_ACTIVE,
    parameter int          V_FP      = DEF_V_FP,
    parameter int          V_SYNC    = DEF_V_SYNC,
    parameter int          V_BP      = DEF_V_BP,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter logic [23:0] SOLID_RGB = DEF_SOLID_RGB
) (
    input  logic        i_pixclk,
    input  logic        i_rst,
    input  logic [1:0]  i_pattern,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit bounds so a sync end equal to 4096 still compares correctly.
    localparam logic [12:0] H_ACT_C = 13'(H_ACTIVE);
    localparam logic [12:0] H_SB_C  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SE_C  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_C = 13'(V_ACTIVE);
    localparam logic [12:0] V_SB_C  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SE_C  = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);

    if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_ACTIVE < 8) begin : g_param_check
        $error("video_timing_gen: totals must fit 12-bit counters and H_ACTIVE must be >= 8");
    end

    logic [11:0] h_cnt_r;
    logic [11:0] v_cnt_r;
    pattern_e    pat_q_r;

    logic [12:0] h_ext_s;
    logic [12:0] v_ext_s;
    logic        de_s;
    logic        hsync_act_s;
    logic        vsync_act_s;
    logic        origin_s;
    pattern_e    pat_sel_s;
    logic [23:0] rgb_s;

    // Decode raster position; at (0,0) the incoming selection applies to the new frame.
    always_comb begin
        h_ext_s     = {1'b0, h_cnt_r};
        v_ext_s     = {1'b0, v_cnt_r};
        de_s        = (h_ext_s < H_ACT_C) && (v_ext_s < V_ACT_C);
        hsync_act_s = (h_ext_s >= H_SB_C) && (h_ext_s < H_SE_C);
        vsync_act_s = (v_ext_s >= V_SB_C) && (v_ext_s < V_SE_C);
        origin_s    = (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
        if (origin_s) begin
            pat_sel_s = pattern_e'(i_pattern);
        end else begin
            pat_sel_s = pat_q_r;
        end
    end

    // Horizontal and vertical counters; v advances only on the h wrap.
    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt_r <= 12'd0;
            v_cnt_r <= 12'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 12'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 12'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 12'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 12'd1;
        end
    end

    // Latch the pattern once per frame so it never changes mid-frame.
    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            pat_q_r <= PAT_BARS;
        end else if (origin_s) begin
            pat_q_r <= pat_sel_s;
        end else begin
            pat_q_r <= pat_q_r;
        end
    end

    video_pattern_gen #(
        .H_ACTIVE  (H_ACTIVE),
        .SOLID_RGB (SOLID_RGB)
    ) u_pattern (
        .x   (h_cnt_r),
        .y   (v_cnt_r),
        .pat (pat_sel_s),
        .de  (de_s),
        .rgb (rgb_s)
    );

    // Single output register stage keeps sync, de, position and RGB aligned.
    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            o_red         <= 8'd0;
            o_green       <= 8'd0;
            o_blue        <= 8'd0;
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_de          <= 1'b0;
            o_x           <= 12'd0;
            o_y           <= 12'd0;
            o_frame_start <= 1'b0;
        end else begin
            {o_red, o_green, o_blue} <= rgb_s;
            o_hsync       <= hsync_act_s ? HSYNC_POL : ~HSYNC_POL;
            o_vsync       <= vsync_act_s ? VSYNC_POL : ~VSYNC_POL;
            o_de          <= de_s;
            o_x           <= de_s ? h_cnt_r : 12'd0;
            o_y           <= de_s ? v_cnt_r : 12'd0;
            o_frame_start <= origin_s;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. Instance A: 640-pixel lines with a
// shortened frame (34 active lines). Instance B: 640-pixel lines, 5-line
// frame for gradient/solid. Instance C: tiny 14x7 raster for wrap-around.
module tb_video_timing_gen;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = 800;
    localparam int AVA = 34, AVF = 2, AVS = 2, AVB = 2, AVT = 40;
    localparam int BVA = 2,  BVF = 1, BVS = 1, BVB = 1, BVT = 5;
    localparam int CHA = 8, CHF = 2, CHS = 2, CHB = 2, CHT = 14;
    localparam int CVA = 4, CVF = 1, CVS = 1, CVB = 1, CVT = 7;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] rgb;
    } vid_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic [1:0] pat_a, pat_b, pat_c;

    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic        a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs, c_hs, c_vs, c_de, c_fs;
    logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;

    vid_t obs_a, obs_b, obs_c;
    assign obs_a = {a_de, a_hs, a_vs, a_fs, a_x, a_y, a_r, a_g, a_b};
    assign obs_b = {b_de, b_hs, b_vs, b_fs, b_x, b_y, b_r, b_g, b_b};
    assign obs_c = {c_de, c_hs, c_vs, c_fs, c_x, c_y, c_r, c_g, c_b};

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB)
    ) dut_a (
        .i_pixclk(clk), .i_rst(rst_a), .i_pattern(pat_a),
        .o_red(a_r), .o_green(a_g), .o_blue(a_b),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
        .o_x(a_x), .o_y(a_y), .o_frame_start(a_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
    ) dut_b (
        .i_pixclk(clk), .i_rst(rst_b), .i_pattern(pat_b),
        .o_red(b_r), .o_green(b_g), .o_blue(b_b),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
        .o_x(b_x), .o_y(b_y), .o_frame_start(b_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(CHA), .H_FP(CHF), .H_SYNC(CHS), .H_BP(CHB),
        .V_ACTIVE(CVA), .V_FP(CVF), .V_SYNC(CVS), .V_BP(CVB)
    ) dut_c (
        .i_pixclk(clk), .i_rst(rst_c), .i_pattern(pat_c),
        .o_red(c_r), .o_green(c_g), .o_blue(c_b),
        .o_hsync(c_hs), .o_vsync(c_vs), .o_de(c_de),
        .o_x(c_x), .o_y(c_y), .o_frame_start(c_fs)
    );

    int vectors = 0;
    int miscompares = 0;
    int ha, va, hb, vb, hc, vc;
    logic [1:0] pf_a, pf_b, pf_c;

    // Expected colour-bar value at column h for an active width of wa.
    function automatic logic [23:0] bar_rgb(input int h, input int wa);
        int idx;
        idx = h / (wa / 8);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Reference outputs for raster position (h,v) with active-low syncs.
    function automatic vid_t model(input int h, input int v, input logic [1:0] pat,
                                   input int wa, input int wf, input int ws,
                                   input int la, input int lf, input int ls);
        vid_t e;
        logic [11:0] hx;
        hx    = 12'(h);
        e.de  = (h < wa) && (v < la);
        e.hs  = !((h >= wa + wf) && (h < wa + wf + ws));
        e.vs  = !((v >= la + lf) && (v < la + lf + ls));
        e.fs  = (h == 0) && (v == 0);
        e.x   = e.de ? 12'(h) : 12'd0;
        e.y   = e.de ? 12'(v) : 12'd0;
        if (!e.de) e.rgb = 24'h000000;
        else begin
            case (pat)
                2'd0:    e.rgb = bar_rgb(h, wa);
                2'd1:    e.rgb = {hx[7:0], hx[7:0], hx[7:0]};
                2'd2:    e.rgb = (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
                default: e.rgb = 24'h808080;
            endcase
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        pat_a = 2'd0; pat_b = 2'd0; pat_c = 2'd0;
        repeat (3) @(negedge clk);
        vectors++; if (a_de !== 1'b0) begin miscompares++; $display("FAIL reset_de: got %b want 0", a_de); end
        vectors++; if ({a_r, a_g, a_b} !== 24'h000000) begin miscompares++; $display("FAIL reset_rgb: got %h want 000000", {a_r, a_g, a_b}); end
        vectors++; if (a_hs !== 1'b1) begin miscompares++; $display("FAIL reset_hsync: got %b want 1", a_hs); end
        vectors++; if (a_vs !== 1'b1) begin miscompares++; $display("FAIL reset_vsync: got %b want 1", a_vs); end
        vectors++; if ({a_x, a_y} !== 24'd0) begin miscompares++; $display("FAIL reset_xy: got %0d,%0d want 0,0", a_x, a_y); end
        vectors++; if (a_fs !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start: got %b want 0", a_fs); end
    endtask

    task automatic test_frame_bars();
        int de_cnt = 0, fs_cnt = 0, hs_cnt = 0, hs_first = -1;
        int vs_cnt = 0, vs_line = -1, vs_h = -1, de_in_sync = 0;
        int spot_x [7] = '{0, 79, 80, 160, 559, 560, 700};
        logic [23:0] spot_rgb [7] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                                      24'h0000FF, 24'h000000, 24'h000000};
        vid_t expv;
        @(negedge clk);
        rst_a = 1'b0; ha = 0; va = 0; pf_a = 2'd0;
        for (int t = 0; t < HT * AVT; t++) begin
            @(negedge clk);
            if (ha == 0 && va == 0) pf_a = pat_a;
            expv = model(ha, va, pf_a, HA, HF, HS, AVA, AVF, AVS);
            vectors++;
            if (obs_a !== expv) begin
                miscompares++;
                $display("FAIL frame_bars (%0d,%0d): got %h want %h", ha, va, obs_a, expv);
            end
            if (va == 0) begin
                for (int k = 0; k < 7; k++) begin
                    if (ha == spot_x[k]) begin
                        vectors++;
                        if ({a_r, a_g, a_b} !== spot_rgb[k]) begin
                            miscompares++;
                            $display("FAIL bar_spot x=%0d: got %h want %h", ha, {a_r, a_g, a_b}, spot_rgb[k]);
                        end
                    end
                end
            end
            if (a_de === 1'b1) de_cnt++;
            if (a_fs === 1'b1) fs_cnt++;
            if (va == 0 && a_hs === 1'b0) begin hs_cnt++; if (hs_first < 0) hs_first = ha; end
            if (a_vs === 1'b0) begin vs_cnt++; if (vs_line < 0) begin vs_line = va; vs_h = ha; end end
            if (a_de === 1'b1 && (a_hs !== 1'b1 || a_vs !== 1'b1)) de_in_sync++;
            if (va == 20 && ha == 0) pat_a = 2'd2;
            ha++; if (ha == HT) begin ha = 0; va++; if (va == AVT) va = 0; end
        end
        vectors++; if (de_cnt != HA * AVA) begin miscompares++; $display("FAIL de_count: got %0d want %0d", de_cnt, HA * AVA); end
        vectors++; if (fs_cnt != 1) begin miscompares++; $display("FAIL frame_start_count: got %0d want 1", fs_cnt); end
        vectors++; if (hs_cnt != 96) begin miscompares++; $display("FAIL hsync_width: got %0d want 96", hs_cnt); end
        vectors++; if (hs_first != 656) begin miscompares++; $display("FAIL hsync_start: got %0d want 656", hs_first); end
        vectors++; if (vs_cnt != 2 * HT) begin miscompares++; $display("FAIL vsync_width: got %0d want %0d", vs_cnt, 2 * HT); end
        vectors++; if (vs_line != 36 || vs_h != 0) begin miscompares++; $display("FAIL vsync_start: got line %0d h %0d want line 36 h 0", vs_line, vs_h); end
        vectors++; if (de_in_sync != 0) begin miscompares++; $display("FAIL de_in_sync: got %0d want 0", de_in_sync); end
    endtask

    task automatic test_pattern_switch();
        vid_t expv;
        for (int t = 0; t < 33 * HT + 301; t++) begin
            @(negedge clk);
            if (ha == 0 && va == 0) pf_a = pat_a;
            expv = model(ha, va, pf_a, HA, HF, HS, AVA, AVF, AVS);
            vectors++;
            if (obs_a !== expv) begin
                miscompares++;
                $display("FAIL checker_frame (%0d,%0d): got %h want %h", ha, va, obs_a, expv);
            end
            if ((ha == 0 && va == 0) || (ha == 32 && va == 32)) begin
                vectors++;
                if ({a_r, a_g, a_b} !== 24'h000000) begin
                    miscompares++;
                    $display("FAIL checker_spot (%0d,%0d): got %h want 000000", ha, va, {a_r, a_g, a_b});
                end
            end
            if (ha == 32 && va == 0) begin
                vectors++;
                if ({a_r, a_g, a_b} !== 24'hFFFFFF) begin
                    miscompares++;
                    $display("FAIL checker_spot (32,0): got %h want FFFFFF", {a_r, a_g, a_b});
                end
            end
            ha++; if (ha == HT) begin ha = 0; va++; if (va == AVT) va = 0; end
        end
    endtask

    task automatic test_reset_midline();
        vid_t expv;
        #2 rst_a = 1'b1;
        #1;
        vectors++; if (a_de !== 1'b0) begin miscompares++; $display("FAIL midreset_de: got %b want 0", a_de); end
        vectors++; if ({a_r, a_g, a_b} !== 24'h000000) begin miscompares++; $display("FAIL midreset_rgb: got %h want 000000", {a_r, a_g, a_b}); end
        vectors++; if ({a_x, a_y} !== 24'd0) begin miscompares++; $display("FAIL midreset_xy: got %0d,%0d want 0,0", a_x, a_y); end
        vectors++; if ({a_hs, a_vs, a_fs} !== 3'b110) begin miscompares++; $display("FAIL midreset_sync: got %b want 110", {a_hs, a_vs, a_fs}); end
        pat_a = 2'd0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; ha = 0; va = 0;
        for (int t = 0; t < 900; t++) begin
            @(negedge clk);
            if (ha == 0 && va == 0) pf_a = pat_a;
            expv = model(ha, va, pf_a, HA, HF, HS, AVA, AVF, AVS);
            vectors++;
            if (obs_a !== expv) begin
                miscompares++;
                $display("FAIL after_reset (%0d,%0d): got %h want %h", ha, va, obs_a, expv);
            end
            if (t == 0) begin
                vectors++;
                if ({a_fs, a_de, a_r, a_g, a_b} !== {2'b11, 24'hFFFFFF}) begin
                    miscompares++;
                    $display("FAIL restart_first_pixel: got fs=%b de=%b rgb=%h want fs=1 de=1 rgb=FFFFFF", a_fs, a_de, {a_r, a_g, a_b});
                end
            end
            ha++; if (ha == HT) begin ha = 0; va++; if (va == AVT) va = 0; end
        end
    endtask

    task automatic test_gradient_solid();
        int fb = -1, solid_cnt = 0;
        vid_t expv;
        @(negedge clk);
        rst_b = 1'b0; hb = 0; vb = 0; pf_b = 2'd0;
        for (int t = 0; t < 3 * HT * BVT; t++) begin
            @(negedge clk);
            if (hb == 0 && vb == 0) begin pf_b = pat_b; fb++; end
            expv = model(hb, vb, pf_b, HA, HF, HS, BVA, BVF, BVS);
            vectors++;
            if (obs_b !== expv) begin
                miscompares++;
                $display("FAIL grad_solid frame %0d (%0d,%0d): got %h want %h", fb, hb, vb, obs_b, expv);
            end
            if (fb == 1 && vb == 0 && (hb == 255 || hb == 256)) begin
                vectors++;
                if ({b_r, b_g, b_b} !== ((hb == 255) ? 24'hFFFFFF : 24'h000000)) begin
                    miscompares++;
                    $display("FAIL gradient_wrap x=%0d: got %h want %h", hb, {b_r, b_g, b_b},
                             (hb == 255) ? 24'hFFFFFF : 24'h000000);
                end
            end
            if (fb == 2 && b_de === 1'b1 && {b_r, b_g, b_b} === 24'h808080) solid_cnt++;
            if (t == 0) pat_b = 2'd1;
            if (fb == 1 && vb == 1 && hb == 0) pat_b = 2'd3;
            hb++; if (hb == HT) begin hb = 0; vb++; if (vb == BVT) vb = 0; end
        end
        vectors++; if (solid_cnt != HA * BVA) begin miscompares++; $display("FAIL solid_count: got %0d want %0d", solid_cnt, HA * BVA); end
    endtask

    task automatic test_small_wrap();
        int fs_cnt = 0, fs_last = -1, fs_gap_bad = 0;
        vid_t expv;
        @(negedge clk);
        rst_c = 1'b0; hc = 0; vc = 0; pf_c = 2'd0;
        for (int t = 0; t < 3 * CHT * CVT; t++) begin
            @(negedge clk);
            if (hc == 0 && vc == 0) pf_c = pat_c;
            expv = model(hc, vc, pf_c, CHA, CHF, CHS, CVA, CVF, CVS);
            vectors++;
            if (obs_c !== expv) begin
                miscompares++;
                $display("FAIL small_wrap (%0d,%0d): got %h want %h", hc, vc, obs_c, expv);
            end
            if (c_fs === 1'b1) begin
                if (fs_last >= 0 && (t - fs_last) != 98) fs_gap_bad++;
                fs_last = t; fs_cnt++;
            end
            if (t == 14) begin
                vectors++;
                if ({c_de, c_x, c_y} !== {1'b1, 12'd0, 12'd1}) begin
                    miscompares++;
                    $display("FAIL small_hwrap: got de=%b x=%0d y=%0d want de=1 x=0 y=1", c_de, c_x, c_y);
                end
            end
            hc++; if (hc == CHT) begin hc = 0; vc++; if (vc == CVT) vc = 0; end
        end
        vectors++; if (fs_cnt != 3 || fs_gap_bad != 0) begin miscompares++; $display("FAIL small_vwrap: got %0d pulses %0d bad gaps want 3 pulses 0 bad gaps", fs_cnt, fs_gap_bad); end
    endtask

    initial begin
        test_reset();
        test_frame_bars();
        test_pattern_switch();
        test_reset_midline();
        test_gradient_solid();
        test_small_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
